// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency request/response handshake.
// One request is captured in IDLE, held for WAIT_CYCLES, then answered with a one-cycle ack.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: req/we/addr/wdata are sampled only on an edge where the state is IDLE;
    // ack is a single-cycle pulse and rdata/err are meaningful while ack=1 (and hold after).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem [DEPTH];

    logic        direct;
    logic        access;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic [7:0]  acc_idx;

    // With zero wait cycles the access happens at the capture edge, straight from the ports.
    assign direct    = (state == IDLE) && req && (WAIT_CYCLES == 0);
    assign access    = !rst && (direct || ((state == WAIT) && (cnt == 4'd1)));
    assign acc_we    = direct ? we    : we_q;
    assign acc_addr  = direct ? addr  : addr_q;
    assign acc_wdata = direct ? wdata : wdata_q;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:10] != 22'd0);
    assign acc_idx   = acc_addr[9:2];

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Storage is deliberately outside the reset domain so reset never clears it.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            ack <= 1'b0;
            if (access) begin
                ack   <= 1'b1;
                err   <= acc_err;
                rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WAIT_INIT;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
